muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_muldiv_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide, sign fix-up.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply in CALC.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] mb;
    logic [WIDTH-1:0] ph;
    logic [WIDTH-1:0] pl;
    logic             neg_q;
    logic             neg_r;
    logic             b_zero;

    // Operand magnitudes are taken at the start edge so CALC only ever sees unsigned values.
    logic a_neg, b_neg;
    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   sub;
    logic               ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    always_comb begin
        mul_sum  = {1'b0, ph} + {1'b0, (pl[0] ? mb : {WIDTH{1'b0}})};
        shifted  = {ph, pl[WIDTH-1]};
        // The true difference always fits WIDTH bits when taken, so truncation is exact.
        sub      = shifted[WIDTH-1:0] - mb;
        ge       = shifted >= {1'b0, mb};
        prod_fix = neg_q ? -{ph, pl} : {ph, pl};
        q_fix    = neg_q ? -pl : pl;
        r_fix    = neg_r ? -ph : ph;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, pl} * {{WIDTH{1'b0}}, mb};
`endif

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_r        <= '0;
            a_r         <= '0;
            mb          <= '0;
            ph          <= '0;
            pl          <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            b_zero      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start && !flush) begin
                        op_r   <= op;
                        a_r    <= a;
                        mb     <= b_neg ? -b : b;
                        pl     <= a_neg ? -a : a;
                        ph     <= '0;
                        cnt    <= CW'(WIDTH - 1);
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        b_zero <= (b == '0);
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (!op_r[1]) begin
`ifdef MULDIV_FAST_MUL_EN
                        {ph, pl} <= fast_prod;
                        state    <= S_FIX;
`else
                        ph  <= mul_sum[WIDTH:1];
                        pl  <= {mul_sum[0], pl[WIDTH-1:1]};
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) state <= S_FIX;
`endif
                    end else begin
                        if (ge) begin
                            ph <= sub;
                            pl <= {pl[WIDTH-2:0], 1'b1};
                        end else begin
                            ph <= shifted[WIDTH-1:0];
                            pl <= {pl[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (!flush) begin
                        done <= 1'b1;
                        if (op_r[1] && b_zero) begin
                            hi          <= a_r;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else if (op_r[1]) begin
                            hi <= r_fix;
                            lo <= q_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst, start, flush, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int pass_cnt = 0;
    int total    = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 3;
    localparam logic [1:0] FLUSH_OP = 2'b11;
`else
    localparam int MUL_LAT = 34;
    localparam logic [1:0] FLUSH_OP = 2'b01;
`endif
    localparam int DIV_LAT = 34;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in an idle cycle; returns in the done cycle with latency in cycles (-1 on timeout).
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output bit busy_ok);
        op = o; a = x; b = y; start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!done && lat < 200) begin
            if (!busy) busy_ok = 1'b0;
            step();
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        total++; if ({hi, lo} !== 64'h0) $display("FAIL reset_hilo got %h want 0", {hi, lo}); else pass_cnt++;
        total++; if ({busy, done, div_by_zero} !== 3'b000)
            $display("FAIL reset_flags got %b want 000", {busy, done, div_by_zero}); else pass_cnt++;
    endtask

    task automatic test_mult();
        int lat; bit bok;
        run_op(2'b00, 32'hFFFFFFFD, 32'd7, lat, bok);
        total++; if (lat !== MUL_LAT) $display("FAIL mult_latency got %0d want %0d", lat, MUL_LAT); else pass_cnt++;
        total++; if (!bok || busy !== 1'b0) $display("FAIL mult_busy busy_ok=%0d busy=%b", bok, busy); else pass_cnt++;
        total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB)
            $display("FAIL mult_result got %h want ffffffffffffffeb", {hi, lo}); else pass_cnt++;
        total++; if (div_by_zero !== 1'b0) $display("FAIL mult_dbz got %b want 0", div_by_zero); else pass_cnt++;
        step();
        total++; if (done !== 1'b0) $display("FAIL done_pulse got %b want 0", done); else pass_cnt++;
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bok);
        total++; if (lat !== MUL_LAT) $display("FAIL multu_latency got %0d want %0d", lat, MUL_LAT); else pass_cnt++;
        total++; if ({hi, lo} !== 64'hFFFFFFFE_00000001)
            $display("FAIL multu_result got %h want fffffffe00000001", {hi, lo}); else pass_cnt++;
        step();
    endtask

    task automatic test_div();
        int lat; bit bok;
        run_op(2'b11, 32'd100, 32'd7, lat, bok);
        total++; if (lat !== DIV_LAT) $display("FAIL divu_latency got %0d want %0d", lat, DIV_LAT); else pass_cnt++;
        total++; if ({hi, lo} !== {32'd2, 32'd14}) $display("FAIL divu_result got %h want 2/14", {hi, lo}); else pass_cnt++;
        step();
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, lat, bok);
        total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD)
            $display("FAIL div_neg got %h want ffffffff_fffffffd", {hi, lo}); else pass_cnt++;
        step();
        run_op(2'b10, 32'd5, 32'd0, lat, bok);
        total++; if ({hi, lo} !== {32'd5, 32'hFFFFFFFF}) $display("FAIL div0_result got %h want 5/ffffffff", {hi, lo}); else pass_cnt++;
        total++; if ({done, div_by_zero} !== 2'b11) $display("FAIL div0_flag got %b want 11", {done, div_by_zero}); else pass_cnt++;
        step();
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, bok);
        total++; if ({hi, lo} !== {32'd0, 32'h80000000}) $display("FAIL div_min got %h want 0/80000000", {hi, lo}); else pass_cnt++;
        total++; if (div_by_zero !== 1'b0) $display("FAIL div_min_dbz got %b want 0", div_by_zero); else pass_cnt++;
        step();
    endtask

    task automatic test_back_to_back();
        int lat; bit bok;
        run_op(2'b11, 32'd50, 32'd8, lat, bok);
        // New start issued directly in the done cycle.
        run_op(2'b11, 32'd1000, 32'd10, lat, bok);
        total++; if (lat !== DIV_LAT) $display("FAIL b2b_latency got %0d want %0d", lat, DIV_LAT); else pass_cnt++;
        total++; if ({hi, lo} !== {32'd0, 32'd100}) $display("FAIL b2b_result got %h want 0/100", {hi, lo}); else pass_cnt++;
        step();
    endtask

    task automatic test_direct_write();
        int n;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h11;
        step();
        hi_we = 1'b0; wdata = 32'h22;
        step();
        lo_we = 1'b0;
        total++; if ({hi, lo} !== {32'h11, 32'h22}) $display("FAIL idle_write got %h want 11/22", {hi, lo}); else pass_cnt++;
        op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1;
        step();
        start = 1'b0; hi_we = 1'b1; wdata = 32'h1234;
        step();
        hi_we = 1'b0;
        n = 2;
        while (!done && n < 200) begin step(); n++; end
        total++; if ({hi, lo} !== {32'd0, 32'd15}) $display("FAIL busy_write got %h want 0/15", {hi, lo}); else pass_cnt++;
        hi_we = 1'b1; wdata = 32'h1234;
        step();
        hi_we = 1'b0;
        total++; if ({hi, lo} !== {32'h1234, 32'd15}) $display("FAIL done_write got %h want 1234/15", {hi, lo}); else pass_cnt++;
    endtask

    task automatic test_flush();
        int lat; bit bok; bit saw_done;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAA;
        step();
        hi_we = 1'b0; lo_we = 1'b0;
        op = FLUSH_OP; a = 32'd77; b = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        saw_done = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (done) saw_done = 1'b1;
            step();
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL flush_busy got %b want 0", busy); else pass_cnt++;
        for (int c = 0; c < 30; c++) begin
            if (done) saw_done = 1'b1;
            step();
        end
        total++; if (saw_done !== 1'b0) $display("FAIL flush_done got %b want 0", saw_done); else pass_cnt++;
        total++; if ({hi, lo} !== {32'hAA, 32'hAA}) $display("FAIL flush_hold got %h want aa/aa", {hi, lo}); else pass_cnt++;
        run_op(2'b01, 32'd6, 32'd7, lat, bok);
        total++; if (lat !== MUL_LAT || {hi, lo} !== {32'd0, 32'd42})
            $display("FAIL flush_next got lat %0d %h want %0d 0/42", lat, {hi, lo}, MUL_LAT); else pass_cnt++;
        step();
        // flush coincident with start in idle wins
        op = 2'b11; a = 32'd9; b = 32'd2; start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL flush_start got busy %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        bit saw_done;
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 5; c++) step();
        rst = 1'b1; hi_we = 1'b1; wdata = 32'h55;
        step();
        rst = 1'b0; hi_we = 1'b0;
        total++; if ({hi, lo, busy, done} !== 66'h0) $display("FAIL reset_midop got %h/%h busy %b done %b want 0",
            hi, lo, busy, done); else pass_cnt++;
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) saw_done = 1'b1;
            step();
        end
        total++; if (saw_done !== 1'b0) $display("FAIL reset_nodone got %b want 0", saw_done); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        #1;
        test_reset();
        test_mult();
        test_div();
        test_back_to_back();
        test_direct_write();
        test_flush();
        test_reset_midop();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
